// File: rtl/vga_sync_decoder.sv
// Recovers column/row counters from raw VGA HSync/VSync, checks the stream against
// the configured frame geometry and declares lock after LOCK_FRAMES clean frames.
//
// state  | meaning
// -------+--------------------------------------------------------------
// SEARCH | waiting for a VSync rise to align the counters; errors ignored
// VERIFY | aligned, counting clean frame boundaries toward lock
// LOCKED | stream matches the geometry; any violation drops back to SEARCH
module vga_sync_decoder #(
   parameter int TOTAL_COLS  = 800,
   parameter int TOTAL_ROWS  = 525,
   parameter int ACTIVE_COLS = 640,
   parameter int ACTIVE_ROWS = 480,
   parameter int LOCK_FRAMES = 2
) (
   input  logic       i_Clk,
   input  logic       i_Rst,
   input  logic       i_HSync,
   input  logic       i_VSync,
   output logic       o_HSync,
   output logic       o_VSync,
   output logic [9:0] o_Col_Count,
   output logic [9:0] o_Row_Count,
   output logic       o_Frame_Start,
   output logic       o_Locked,
   output logic       o_Error
);

   // The active sizes only shape the generator's sync pulses; here they just bound the geometry.
   if (TOTAL_COLS > 1024 || ACTIVE_COLS < 1 || ACTIVE_COLS >= TOTAL_COLS) begin : g_bad_cols
      $error("vga_sync_decoder: invalid column geometry");
   end
   if (TOTAL_ROWS > 1024 || ACTIVE_ROWS < 1 || ACTIVE_ROWS >= TOTAL_ROWS) begin : g_bad_rows
      $error("vga_sync_decoder: invalid row geometry");
   end
   if (LOCK_FRAMES < 1 || LOCK_FRAMES > 15) begin : g_bad_lock
      $error("vga_sync_decoder: LOCK_FRAMES out of range");
   end

   localparam logic [9:0] COL_LAST = 10'(TOTAL_COLS - 1);
   localparam logic [9:0] ROW_LAST = 10'(TOTAL_ROWS - 1);
   localparam logic [3:0] LOCK_CNT = 4'(LOCK_FRAMES);

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t     state, state_nxt;
   logic [3:0] good_cnt, good_cnt_nxt;
   logic       r_h, r_v;
   logic [9:0] col, row, col_nxt, row_nxt, row_inc;
   logic       h_rise, v_rise, col_end, frame_end, h_err, v_err, err;

   assign h_rise    = i_HSync & ~r_h;
   assign v_rise    = i_VSync & ~r_v;
   assign col_end   = (col == COL_LAST);
   assign frame_end = col_end && (row == ROW_LAST);
   assign h_err     = h_rise ^ col_end;
   assign v_err     = v_rise ^ frame_end;
   assign err       = (h_err | v_err) && (state != SEARCH);

   // VSync rise wins over HSync rise so a legal coincident boundary lands on row 0.
   always_comb begin
      row_inc = (row == ROW_LAST) ? 10'd0 : row + 10'd1;
      col_nxt = col + 10'd1;
      row_nxt = row;
      if (v_rise) begin
         col_nxt = 10'd0;
         row_nxt = 10'd0;
      end else if (h_rise || col_end) begin
         col_nxt = 10'd0;
         row_nxt = row_inc;
      end
   end

   always_comb begin
      state_nxt    = state;
      good_cnt_nxt = good_cnt;
      case (state)
         SEARCH: begin
            if (v_rise) begin
               state_nxt    = VERIFY;
               good_cnt_nxt = 4'd0;
            end
         end
         VERIFY: begin
            if (err) begin
               state_nxt    = SEARCH;
               good_cnt_nxt = 4'd0;
            end else if (v_rise) begin
               good_cnt_nxt = good_cnt + 4'd1;
               if (good_cnt + 4'd1 == LOCK_CNT) state_nxt = LOCKED;
            end
         end
         LOCKED: begin
            if (err) begin
               state_nxt    = SEARCH;
               good_cnt_nxt = 4'd0;
            end
         end
         default: begin
            state_nxt    = SEARCH;
            good_cnt_nxt = 4'd0;
         end
      endcase
   end

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         state         <= SEARCH;
         good_cnt      <= 4'd0;
         r_h           <= 1'b0;
         r_v           <= 1'b0;
         col           <= 10'd0;
         row           <= 10'd0;
         o_Frame_Start <= 1'b0;
         o_Error       <= 1'b0;
      end else begin
         state         <= state_nxt;
         good_cnt      <= good_cnt_nxt;
         r_h           <= i_HSync;
         r_v           <= i_VSync;
         col           <= col_nxt;
         row           <= row_nxt;
         o_Frame_Start <= v_rise;
         o_Error       <= err;
      end
   end

   assign o_HSync     = r_h;
   assign o_VSync     = r_v;
   assign o_Col_Count = col;
   assign o_Row_Count = row;
   assign o_Locked    = (state == LOCKED);

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a reduced 20x12 frame so many frames fit in a short run.
module tb_vga_sync_decoder;

   localparam int TC = 20;
   localparam int TR = 12;
   localparam int AC = 16;
   localparam int AR = 9;
   localparam int LF = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       hs = 1'b0;
   logic       vs = 1'b0;
   logic       o_hs, o_vs, o_fs, o_lock, o_err;
   logic [9:0] o_col, o_row;

   int gen_col, gen_row, smp_col, smp_row;
   int frame_rows = TR;
   int skip_row   = -1;
   bit align_on   = 1'b0;
   int align_bad  = 0;
   int err_pulses = 0;
   int n_checks   = 0;
   int n_errors   = 0;

   vga_sync_decoder #(
      .TOTAL_COLS (TC),
      .TOTAL_ROWS (TR),
      .ACTIVE_COLS(AC),
      .ACTIVE_ROWS(AR),
      .LOCK_FRAMES(LF)
   ) dut (
      .i_Clk        (clk),
      .i_Rst        (rst),
      .i_HSync      (hs),
      .i_VSync      (vs),
      .o_HSync      (o_hs),
      .o_VSync      (o_vs),
      .o_Col_Count  (o_col),
      .o_Row_Count  (o_row),
      .o_Frame_Start(o_fs),
      .o_Locked     (o_lock),
      .o_Error      (o_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drive the generator position, clock it in, then advance the generator.
   task automatic step();
      hs = (gen_col < AC) && (gen_row != skip_row);
      vs = (gen_row < AR);
      @(posedge clk);
      #1;
      smp_col = gen_col;
      smp_row = gen_row;
      if (gen_col == TC - 1) begin
         gen_col = 0;
         if (gen_row >= frame_rows - 1) begin
            gen_row    = 0;
            frame_rows = TR;
         end else begin
            gen_row++;
         end
      end else begin
         gen_col++;
      end
      if (o_err) err_pulses++;
      if (align_on && (int'(o_col) != smp_col || int'(o_row) != smp_row)) align_bad++;
   endtask

   task automatic run_to(input int c, input int r);
      int n = 0;
      do begin
         step();
         n++;
      end while (!(smp_col == c && smp_row == r) && n < 2000);
      chk("reach_position", int'(smp_col == c && smp_row == r), 1);
   endtask

   function automatic int all_outs();
      return int'({o_hs, o_vs, o_col, o_row, o_fs, o_lock, o_err});
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      gen_col = 17;
      gen_row = 10;
      #1 rst = 1'b1;
      #1;
      chk("reset_outputs", all_outs(), 0);
      repeat (3) step();
      chk("reset_held_outputs", all_outs(), 0);
      rst = 1'b0;
      err_pulses = 0;

      // First VSync rise aligns the counters
      run_to(0, 0);
      chk("v1_frame_start", int'(o_fs), 1);
      chk("v1_col", int'(o_col), 0);
      chk("v1_row", int'(o_row), 0);
      chk("v1_locked", int'(o_lock), 0);
      chk("search_no_error", err_pulses, 0);
      align_on  = 1'b1;
      align_bad = 0;

      run_to(AC - 1, AR - 1);
      chk("last_active_col", int'(o_col), AC - 1);
      chk("last_active_row", int'(o_row), AR - 1);
      chk("last_active_syncs", int'({o_hs, o_vs}), 3);
      step();
      chk("hsync_fall", int'(o_hs), 0);
      run_to(TC - 1, TR - 1);
      chk("frame_end_col", int'(o_col), TC - 1);
      chk("frame_end_row", int'(o_row), TR - 1);
      chk("frame_end_fs", int'(o_fs), 0);
      step();
      chk("v2_frame_start", int'(o_fs), 1);
      chk("v2_locked", int'(o_lock), 0);
      run_to(TC - 1, TR - 1);
      chk("pre_v3_locked", int'(o_lock), 0);
      step();
      chk("v3_frame_start", int'(o_fs), 1);
      chk("v3_locked", int'(o_lock), 1);
      chk("coincident_row", int'(o_row), 0);
      chk("coincident_col", int'(o_col), 0);
      chk("clean_no_error", err_pulses, 0);
      step();
      chk("fs_one_cycle", int'(o_fs), 0);

      // Missing HSync on line 5
      err_pulses = 0;
      skip_row = 5;
      run_to(TC - 1, 4);
      chk("pre_skip_locked", int'(o_lock), 1);
      step();
      chk("skip_error", int'(o_err), 1);
      chk("skip_unlock", int'(o_lock), 0);
      chk("skip_row_count", int'(o_row), 5);
      step();
      chk("skip_error_pulse", int'(o_err), 0);
      run_to(TC - 1, 5);
      skip_row = -1;
      run_to(0, 0);
      chk("relock_v1", int'(o_lock), 0);
      run_to(0, 0);
      chk("relock_v2", int'(o_lock), 0);
      run_to(0, 0);
      chk("relock_v3", int'(o_lock), 1);
      chk("skip_error_count", err_pulses, 1);

      // Truncated frame: VSync rises after 10 lines
      err_pulses = 0;
      frame_rows = 10;
      run_to(TC - 1, 9);
      chk("pre_trunc_locked", int'(o_lock), 1);
      step();
      chk("trunc_error", int'(o_err), 1);
      chk("trunc_fs", int'(o_fs), 1);
      chk("trunc_counts", int'({o_col, o_row}), 0);
      chk("trunc_unlock", int'(o_lock), 0);
      run_to(0, 0);
      chk("trunc_v1_locked", int'(o_lock), 0);
      run_to(0, 0);
      chk("trunc_v2_locked", int'(o_lock), 0);
      run_to(0, 0);
      chk("trunc_v3_locked", int'(o_lock), 1);
      chk("trunc_error_count", err_pulses, 1);

      // Asynchronous reset mid-line while locked
      run_to(17, 10);
      chk("pre_rst_locked", int'(o_lock), 1);
      rst = 1'b1;
      #1;
      chk("async_reset_outputs", all_outs(), 0);
      align_on = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      err_pulses = 0;
      run_to(TC - 1, TR - 1);
      chk("post_rst_locked", int'(o_lock), 0);
      chk("post_rst_no_error", err_pulses, 0);
      step();
      chk("post_rst_fs", int'(o_fs), 1);
      chk("post_rst_counts", int'({o_col, o_row}), 0);
      chk("post_rst_v_error", int'(o_err), 0);
      align_on = 1'b1;
      run_to(0, 0);
      chk("post_rst_v2_locked", int'(o_lock), 0);
      run_to(0, 0);
      chk("post_rst_v3_locked", int'(o_lock), 1);
      chk("post_rst_error_count", err_pulses, 0);
      chk("count_alignment", align_bad, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
